// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// One digit slot per REFRESH_DIV cycles; each slot opens with GUARD_CYCLES of
// anodes-off so the shared decoder settles before the digit lights.
// Game logic loads new values into a staging register; they reach the
// displayed shadow only at a frame boundary, so a frame never tears.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      lz_blank_en,
    input  logic                      load,
    output logic                      load_ack,
    output logic [3:0]                digit_num,
    output logic                      digit_blank,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      dp,
    output logic                      frame_start
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] G_LAST  = PW'(GUARD_CYCLES - 1);
    localparam bit            HAS_GRD = (GUARD_CYCLES > 0);

    typedef enum logic {S_GUARD, S_DRIVE} slot_t;

    slot_t                         slot;
    logic [PW-1:0]                 prescaler;
    logic [IW-1:0]                 idx;
    logic [NUM_DIGITS-1:0][3:0]    stage_val;
    logic [NUM_DIGITS-1:0]         stage_dp;
    logic                          stage_pending;
    logic [NUM_DIGITS-1:0][3:0]    shadow_val;
    logic [NUM_DIGITS-1:0]         shadow_dp;

    logic                          slot_end;
    logic                          boundary;
    logic [NUM_DIGITS-1:0]         zero_from;
    logic                          suppress;
    logic [NUM_DIGITS-1:0]         an_nxt;

    assign slot_end = (prescaler == P_LAST);
    assign boundary = slot_end && (idx == I_LAST);

    // Slot timing: prescaler, digit index and the GUARD/DRIVE state that
    // tracks where the prescaler sits inside the current slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler <= '0;
            idx       <= '0;
            slot      <= HAS_GRD ? S_GUARD : S_DRIVE;
        end else begin
            if (slot_end) begin
                prescaler <= '0;
                idx       <= (idx == I_LAST) ? '0 : idx + 1'b1;
                slot      <= HAS_GRD ? S_GUARD : S_DRIVE;
            end else begin
                prescaler <= prescaler + 1'b1;
                if (HAS_GRD && prescaler == G_LAST)
                    slot <= S_DRIVE;
            end
        end
    end

    // Staging and shadow buffers; a load on the boundary cycle itself
    // skips staging and lands directly in the shadow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_val     <= '0;
            stage_dp      <= '0;
            stage_pending <= 1'b0;
            shadow_val    <= '0;
            shadow_dp     <= '0;
        end else if (boundary && load) begin
            stage_val     <= value_in;
            stage_dp      <= dp_in;
            stage_pending <= 1'b0;
            shadow_val    <= value_in;
            shadow_dp     <= dp_in;
        end else if (boundary && stage_pending) begin
            stage_pending <= 1'b0;
            shadow_val    <= stage_val;
            shadow_dp     <= stage_dp;
        end else if (load) begin
            stage_val     <= value_in;
            stage_dp      <= dp_in;
            stage_pending <= 1'b1;
        end
    end

    // zero_from[i] is set when shadow digits i..NUM_DIGITS-1 are all zero.
    always_comb begin
        zero_from = '0;
        zero_from[NUM_DIGITS-1] = (shadow_val[NUM_DIGITS-1] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            zero_from[i] = zero_from[i+1] && (shadow_val[i] == 4'h0);
    end

    // Leading-zero blanking never applies to the rightmost digit.
    assign suppress = lz_blank_en && (idx != '0) && zero_from[idx];

    // Only the active digit's anode is pulled low, and only while driving.
    always_comb begin
        an_nxt = '1;
        if (slot == S_DRIVE)
            an_nxt[idx] = 1'b0;
    end

    // Registered pin drivers; the nibble is presented during GUARD as well
    // so the decoder output is stable before the anode switches on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an          <= '1;
            dp          <= 1'b1;
            digit_num   <= 4'h0;
            digit_blank <= 1'b1;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nxt;
            dp          <= (slot == S_DRIVE) ? ~shadow_dp[idx] : 1'b1;
            digit_num   <= shadow_val[idx];
            digit_blank <= (slot == S_GUARD) || suppress;
            load_ack    <= boundary && (stage_pending || load);
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8,
// GUARD_CYCLES=2. After reset release, the outputs seen after tick k reflect
// counter position c=k-1: slot p=c%8, digit idx=(c/8)%4, frame boundary at
// c%32==31.
module tb_sevenseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        lz_blank_en;
    logic        load;
    logic        load_ack;
    logic [3:0]  digit_num;
    logic        digit_blank;
    logic [3:0]  an;
    logic        dp;
    logic        frame_start;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acks  = 0;

    sevenseg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .GUARD_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .lz_blank_en(lz_blank_en),
        .load       (load),
        .load_ack   (load_ack),
        .digit_num  (digit_num),
        .digit_blank(digit_blank),
        .an         (an),
        .dp         (dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc=%0d: got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        value_in    = 16'h0;
        dp_in       = 4'h0;
        lz_blank_en = 1'b0;
        load        = 1'b0;

        // reset held for three cycles
        repeat (3) tick();
        chk("rst_an",    an, 4'b1111);
        chk("rst_blank", digit_blank, 1'b1);
        chk("rst_dp",    dp, 1'b1);
        chk("rst_num",   digit_num, 4'h0);
        chk("rst_ack",   load_ack, 1'b0);
        chk("rst_fs",    frame_start, 1'b0);

        // scan after release
        rst_n = 1'b1;
        cyc   = 0;
        tick(); chk("g0_an1", an, 4'b1111); chk("g0_blank", digit_blank, 1'b1);
        tick(); chk("g0_an2", an, 4'b1111);
        for (int k = 3; k <= 8; k++) begin
            tick();
            chk("d0_an", an, 4'b1110);
        end
        tick(); chk("g1_an", an, 4'b1111);
        run_to(11);
        chk("d1_an", an, 4'b1101);
        chk("d1_blank", digit_blank, 1'b0);
        chk("d1_dp", dp, 1'b1);
        run_to(31); chk("fs_pre", frame_start, 1'b0);
        tick();     chk("fs_32", frame_start, 1'b1); chk("ack_none", load_ack, 1'b0);
        tick();     chk("fs_33", frame_start, 1'b0);

        // mid-frame load held until boundary
        run_to(40);
        value_in = 16'h12AB; load = 1'b1;
        tick();
        load = 1'b0;
        run_to(50); chk("hold_num50", digit_num, 4'h0);
        run_to(60); chk("hold_num60", digit_num, 4'h0);
        run_to(64);
        chk("hold_num64", digit_num, 4'h0);
        chk("ack_64", load_ack, 1'b1);
        chk("fs_64",  frame_start, 1'b1);
        tick();
        chk("ack_65", load_ack, 1'b0);
        chk("num_b_g", digit_num, 4'hB);
        chk("an_g", an, 4'b1111);
        run_to(67); chk("num_b", digit_num, 4'hB); chk("an_b", an, 4'b1110); chk("blank_b", digit_blank, 1'b0);
        run_to(75); chk("num_a", digit_num, 4'hA);
        run_to(83); chk("num_2", digit_num, 4'h2);
        run_to(91); chk("num_1", digit_num, 4'h1);

        // two loads in one frame: latest wins, one ack
        run_to(70);
        value_in = 16'h1111; load = 1'b1;
        tick();
        load = 1'b0;
        run_to(80);
        value_in = 16'h2222; load = 1'b1;
        tick();
        load = 1'b0;
        acks = 0;
        while (cyc < 127) begin
            tick();
            if (load_ack) acks++;
            if (cyc == 96)  chk("ack_96", load_ack, 1'b1);
            if (cyc == 99)  chk("num_2222_d0", digit_num, 4'h2);
            if (cyc == 123) chk("num_2222_d3", digit_num, 4'h2);
        end
        chk("ack_count", acks, 1);

        // load on the boundary cycle itself
        value_in = 16'h00F0; load = 1'b1;
        tick();
        load = 1'b0;
        chk("bnd_ack", load_ack, 1'b1);
        chk("bnd_fs",  frame_start, 1'b1);
        tick();
        chk("bnd_ack_off", load_ack, 1'b0);
        chk("bnd_num0", digit_num, 4'h0);
        run_to(139);
        chk("bnd_numF", digit_num, 4'hF);
        chk("bnd_anF",  an, 4'b1101);

        // leading-zero blanking and decimal point
        run_to(140);
        value_in = 16'h0050; dp_in = 4'b1000; lz_blank_en = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        run_to(160); chk("lz_ack", load_ack, 1'b1);
        run_to(163);
        chk("lz_d0_num", digit_num, 4'h0); chk("lz_d0_blank", digit_blank, 1'b0);
        chk("lz_d0_an", an, 4'b1110);      chk("lz_d0_dp", dp, 1'b1);
        run_to(171);
        chk("lz_d1_num", digit_num, 4'h5); chk("lz_d1_blank", digit_blank, 1'b0);
        run_to(179);
        chk("lz_d2_blank", digit_blank, 1'b1); chk("lz_d2_an", an, 4'b1011);
        chk("lz_d2_dp", dp, 1'b1);
        run_to(185);
        chk("lz_d3g_dp", dp, 1'b1); chk("lz_d3g_an", an, 4'b1111);
        run_to(187);
        chk("lz_d3_blank", digit_blank, 1'b1); chk("lz_d3_dp", dp, 1'b0);
        chk("lz_d3_an", an, 4'b0111);

        // reset mid-drive of digit 2 with a load pending
        lz_blank_en = 1'b0;
        run_to(200);
        value_in = 16'h9999; dp_in = 4'b1111; load = 1'b1;
        tick();
        load = 1'b0;
        run_to(211);
        chk("pre_rst_an", an, 4'b1011);
        rst_n = 1'b0;
        tick();
        chk("mr_an", an, 4'b1111); chk("mr_blank", digit_blank, 1'b1);
        chk("mr_dp", dp, 1'b1);    chk("mr_num", digit_num, 4'h0);
        chk("mr_ack", load_ack, 1'b0);
        rst_n = 1'b1;
        cyc   = 0;
        acks  = 0;
        while (cyc < 35) begin
            tick();
            if (load_ack) acks++;
            if (cyc == 2)  chk("mr_g_an", an, 4'b1111);
            if (cyc == 3)  begin chk("mr_d0_an", an, 4'b1110); chk("mr_d0_num", digit_num, 4'h0); end
            if (cyc == 32) chk("mr_fs", frame_start, 1'b1);
            if (cyc == 35) begin chk("mr_shadow0", digit_num, 4'h0); chk("mr_dp_off", dp, 1'b1); end
        end
        chk("mr_ack_count", acks, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
